// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: per-channel prescaler, up-counter and compare with
// one-cycle match events and a sticky, maskable interrupt status register.
module apb_timer_mc #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [11:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] event_o,
  output logic              irq_o
);

  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

  logic [NUM_CH-1:0]  en_q, oneshot_q, irq_en_q, irq_status_q;
  logic [PRESC_W-1:0] presc_q [NUM_CH];
  logic [PRESC_W-1:0] pre_q   [NUM_CH];
  logic [CNT_W-1:0]   cmp_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];

  logic              access, wr_acc, is_irq, is_ch, addr_err;
  logic [3:0]        ch_idx;
  logic [1:0]        reg_sel;
  logic [NUM_CH-1:0] tick, match, wr_cfg, wr_cmp, wr_cnt, irq_clr;
  logic              unused_wdata;

  // APB: a transfer is one setup cycle (PSEL) then one access cycle
  // (PSEL & PENABLE); PREADY is tied high, so every access phase completes
  // on the edge that ends it, which is when writes land.
  assign access   = PSEL & PENABLE;
  assign ch_idx   = PADDR[7:4];
  assign reg_sel  = PADDR[3:2];
  assign is_irq   = (PADDR == 12'h100);
  assign is_ch    = (PADDR[11:8] == 4'h0) && (ch_idx <= LAST_CH) &&
                    (reg_sel != 2'd3) && (PADDR[1:0] == 2'b00);
  assign addr_err = ~(is_irq | is_ch);
  assign wr_acc   = access & PWRITE & ~addr_err;
  assign PREADY   = 1'b1;
  assign PSLVERR  = access & addr_err;
  assign irq_clr  = (wr_acc && is_irq) ? PWDATA[NUM_CH-1:0] : '0;
  assign unused_wdata = ^PWDATA;

  // Match is judged on the pre-write counter value of this cycle.
  always_comb begin
    tick   = '0;
    match  = '0;
    wr_cfg = '0;
    wr_cmp = '0;
    wr_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tick[c]   = en_q[c] && (pre_q[c] == presc_q[c]);
      match[c]  = tick[c] && (cnt_q[c] == cmp_q[c]);
      wr_cfg[c] = wr_acc && is_ch && (ch_idx == 4'(c)) && (reg_sel == 2'd0);
      wr_cmp[c] = wr_acc && is_ch && (ch_idx == 4'(c)) && (reg_sel == 2'd1);
      wr_cnt[c] = wr_acc && is_ch && (ch_idx == 4'(c)) && (reg_sel == 2'd2);
    end
  end

  always_comb begin
    PRDATA = '0;
    if (access && !addr_err) begin
      if (is_irq) begin
        PRDATA[NUM_CH-1:0] = irq_status_q;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_idx == 4'(c)) begin
            case (reg_sel)
              2'd0: begin
                PRDATA[2:0]          = {irq_en_q[c], oneshot_q[c], en_q[c]};
                PRDATA[8 +: PRESC_W] = presc_q[c];
              end
              2'd1:    PRDATA[CNT_W-1:0] = cmp_q[c];
              2'd2:    PRDATA[CNT_W-1:0] = cnt_q[c];
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Later assignments win: bus writes override the tick update of the same edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q         <= '0;
      oneshot_q    <= '0;
      irq_en_q     <= '0;
      irq_status_q <= '0;
      event_o      <= '0;
      irq_o        <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        presc_q[c] <= '0;
        pre_q[c]   <= '0;
        cmp_q[c]   <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!en_q[c] || tick[c]) pre_q[c] <= '0;
        else                     pre_q[c] <= pre_q[c] + PRESC_W'(1);

        if (match[c]) begin
          if (oneshot_q[c]) en_q[c]  <= 1'b0;
          else              cnt_q[c] <= '0;
        end else if (tick[c]) begin
          cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        end

        if (wr_cfg[c]) begin
          en_q[c]      <= PWDATA[0];
          oneshot_q[c] <= PWDATA[1];
          irq_en_q[c]  <= PWDATA[2];
          presc_q[c]   <= PWDATA[8 +: PRESC_W];
          if (PWDATA[3]) begin
            cnt_q[c] <= '0;
            pre_q[c] <= '0;
          end
        end
        if (wr_cmp[c]) cmp_q[c] <= PWDATA[CNT_W-1:0];
        if (wr_cnt[c]) cnt_q[c] <= PWDATA[CNT_W-1:0];
      end
      event_o      <= match;
      irq_status_q <= (irq_status_q & ~irq_clr) | match;
      irq_o        <= |(irq_status_q & irq_en_q);
    end
  end

endmodule
